// File: rtl/two_one_merge_mux.sv
// Two-input round-robin merge into a single registered output slot.
// Each output word carries a source tag so a downstream 1:2 demux can split the stream again.
module two_one_merge_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  src_t last_grant;
  logic slot_free;
  logic grant_a;
  logic grant_b;
  logic take_a;
  logic take_b;

  assign slot_free = !out_valid || out_ready;

  // Contention goes to whichever channel did not win the previous transfer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if (last_grant == SRC_A) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else if (a_valid) begin
      grant_a = 1'b1;
    end else if (b_valid) begin
      grant_b = 1'b1;
    end
  end

  // Ready is forced low while reset is held so no handshake can be claimed mid-reset.
  assign a_ready = rst_n && slot_free && grant_a;
  assign b_ready = rst_n && slot_free && grant_b;

  assign take_a = a_valid && a_ready;
  assign take_b = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else if (take_a) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_sel   <= SRC_A;
    end else if (take_b) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_sel   <= SRC_B;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_B;
    end else if (take_a) begin
      last_grant <= SRC_A;
    end else if (take_b) begin
      last_grant <= SRC_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 16'h0000;
      cnt_b <= 16'h0000;
    end else begin
      if (take_a) begin
        cnt_a <= cnt_a + 16'h0001;
      end
      if (take_b) begin
        cnt_b <= cnt_b + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_two_one_merge_mux.sv
// Self-checking bench for two_one_merge_mux: directed scenarios plus randomized traffic
// compared against a transaction-level model of the merge slot.
module tb_two_one_merge_mux;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;
  logic [15:0]      cnt_a;
  logic [15:0]      cnt_b;

  int checks;
  int failures;

  // Model state: the word sitting in the output slot, who won last, and the word counts.
  bit             m_valid;
  bit [WIDTH-1:0] m_data;
  bit             m_sel;
  bit             m_last_b;
  int             m_cnt_a;
  int             m_cnt_b;

  two_one_merge_mux #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_sel    = 1'b0;
    m_last_b = 1'b1;
    m_cnt_a  = 0;
    m_cnt_b  = 0;
  endtask

  // Which channel the model expects to win this cycle: 0 none, 1 a, 2 b.
  function automatic int model_winner();
    if (!(!m_valid || out_ready)) return 0;
    if (a_valid && b_valid) return m_last_b ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  function automatic logic [43:0] model_expect();
    int w;
    w = model_winner();
    return {m_valid, m_data, m_sel, m_cnt_a[15:0], m_cnt_b[15:0], w == 1, w == 2};
  endfunction

  function automatic logic [43:0] observed();
    return {out_valid, out_data, out_sel, cnt_a, cnt_b, a_ready, b_ready};
  endfunction

  // Advance the model by one rising edge using the inputs presented during the cycle.
  task automatic model_edge();
    int w;
    w = model_winner();
    if (w == 1) begin
      m_valid = 1'b1; m_data = a_data; m_sel = 1'b0; m_last_b = 1'b0;
      m_cnt_a = (m_cnt_a + 1) % 65536;
    end else if (w == 2) begin
      m_valid = 1'b1; m_data = b_data; m_sel = 1'b1; m_last_b = 1'b1;
      m_cnt_b = (m_cnt_b + 1) % 65536;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit av, input bit [WIDTH-1:0] ad, input bit bv,
                       input bit [WIDTH-1:0] bd, input bit orr);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = orr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 8'hA5, 1, 8'h5A, 1);
    model_reset();
    #1;
    checks++;
    if (observed() !== 44'h0) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h exp=%h", observed(), 44'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, a_ready, b_ready, cnt_a} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL reset_held got=%h exp=%h", {out_valid, a_ready, b_ready, cnt_a}, 19'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 8'h11, 1, 8'h22, 1);
      #1;
      checks++;
      if (observed() !== model_expect()) begin
        failures++;
        $display("[TB] FAIL rr_cycle%0d got=%h exp=%h", i, observed(), model_expect());
      end
      if (i >= 1) begin
        checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, (i % 2 == 1) ? 8'h11 : 8'h22, (i % 2 == 0)}) begin
          failures++;
          $display("[TB] FAIL rr_seq%0d got=%h exp=%h", i, {out_valid, out_data, out_sel},
                   {1'b1, (i % 2 == 1) ? 8'h11 : 8'h22, (i % 2 == 0)});
        end
        checks++;
        if (!((cnt_a - cnt_b == 16'd1) || (cnt_a == cnt_b))) begin
          failures++;
          $display("[TB] FAIL rr_balance got=a%0d/b%0d exp=diff<=1", cnt_a, cnt_b);
        end
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_b_only();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 8'h00, 1, 8'h5A, 1);
      #1;
      checks++;
      if (observed() !== model_expect()) begin
        failures++;
        $display("[TB] FAIL b_only%0d got=%h exp=%h", i, observed(), model_expect());
      end
      checks++;
      if (a_ready !== 1'b0 || (i >= 1 && {out_valid, out_data, out_sel} !== {1'b1, 8'h5A, 1'b1})) begin
        failures++;
        $display("[TB] FAIL b_only_word%0d got=%h exp=%h", i, {a_ready, out_valid, out_data, out_sel},
                 {1'b0, 1'b1, 8'h5A, 1'b1});
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held_a;
    logic [15:0] held_b;
    do_reset();
    @(negedge clk);
    drive(1, 8'h33, 0, 8'h00, 0);
    @(posedge clk);
    model_edge();
    held_a = m_cnt_a[15:0];
    held_b = m_cnt_b[15:0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 8'h44, 1, 8'h55, 0);
      #1;
      checks++;
      if ({out_valid, out_data, a_ready, b_ready, cnt_a, cnt_b} !==
          {1'b1, 8'h33, 1'b0, 1'b0, held_a, held_b}) begin
        failures++;
        $display("[TB] FAIL stall%0d got=%h exp=%h", i,
                 {out_valid, out_data, a_ready, b_ready, cnt_a, cnt_b},
                 {1'b1, 8'h33, 1'b0, 1'b0, held_a, held_b});
      end
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    drive(1, 8'h44, 1, 8'h55, 1);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL stall_release got=%b exp=%b", {a_ready, b_ready}, 2'b01);
    end
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 8'h55, 1'b1}) begin
      failures++;
      $display("[TB] FAIL stall_next got=%h exp=%h", {out_valid, out_data, out_sel}, {1'b1, 8'h55, 1'b1});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
            $urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (observed() !== model_expect()) begin
        failures++;
        $display("[TB] FAIL random%0d got=%h exp=%h", i, observed(), model_expect());
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      drive(1, 8'(i), 0, 8'h00, 1);
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    checks++;
    if ({cnt_a, cnt_b} !== {16'hFFFF, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL wrap_preload got=%h exp=%h", {cnt_a, cnt_b}, {16'hFFFF, 16'h0000});
    end
    drive(1, 8'h77, 0, 8'h00, 1);
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if ({cnt_a, cnt_b} !== {16'h0000, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL wrap_rollover got=%h exp=%h", {cnt_a, cnt_b}, {16'h0000, 16'h0000});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 8'h66, 1, 8'h99, 0);
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_valid, cnt_a, cnt_b} !== 33'h0) begin
      failures++;
      $display("[TB] FAIL async_clear got=%h exp=%h", {out_valid, cnt_a, cnt_b}, 33'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'hC1, 1, 8'hC2, 1);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL async_first_grant got=%b exp=%b", {a_ready, b_ready}, 2'b10);
    end
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if ({out_valid, out_data, out_sel, cnt_a} !== {1'b1, 8'hC1, 1'b0, 16'h0001}) begin
      failures++;
      $display("[TB] FAIL async_first_word got=%h exp=%h", {out_valid, out_data, out_sel, cnt_a},
               {1'b1, 8'hC1, 1'b0, 16'h0001});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_round_robin();
    test_b_only();
    test_backpressure();
    test_random();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/two_one_merge_mux.md
TWO_ONE_MERGE_MUX -- requirements
Module: two_one_merge_mux

Interface
REQ-001 Parameter WIDTH, default 8, sets the payload width of both input channels and the output channel.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a_valid  input  1  channel 0 holds a word.
REQ-005 a_data  input  WIDTH  channel 0 payload.
REQ-006 a_ready  output  1  channel 0 word accepted this cycle when high with a_valid.
REQ-007 b_valid  input  1  channel 1 holds a word.
REQ-008 b_data  input  WIDTH  channel 1 payload.
REQ-009 b_ready  output  1  channel 1 word accepted this cycle when high with b_valid.
REQ-010 out_valid  output  1  registered output word present.
REQ-011 out_data  output  WIDTH  registered output payload.
REQ-012 out_sel  output  1  source tag of out_data: 0 = channel 0 (a), 1 = channel 1 (b); a downstream 1:2 demux routes on it.
REQ-013 out_ready  input  1  consumer takes the output word this cycle when high with out_valid.
REQ-014 cnt_a  output  16  count of words accepted from channel 0.
REQ-015 cnt_b  output  16  count of words accepted from channel 1.

Function
REQ-016 Transfer on any channel occurs exactly on a rising edge where valid and ready are both high.
REQ-017 The output stage is one register slot (out_valid, out_data, out_sel); slot_free = !out_valid || out_ready.
REQ-018 Grant is combinational: only a_valid -> grant a; only b_valid -> grant b; both -> the channel not granted last (round-robin); neither -> no grant.
REQ-019 a_ready = slot_free && grant a; b_ready = slot_free && grant b; at most one of them is high in any cycle.
REQ-020 a_ready and b_ready are independent of out_valid's own history beyond slot_free; they depend on a_valid/b_valid only through the grant.
REQ-021 On an input transfer, the slot loads data and tag on the next edge with out_valid = 1; latency is 1 cycle from input transfer to out_valid.
REQ-022 Simultaneous output drain and input transfer in one cycle: the slot is overwritten with the new word; out_valid stays 1; no bubble; full throughput of 1 word per cycle.
REQ-023 Output drain with no input transfer: out_valid -> 0 on the next edge.
REQ-024 While out_valid = 1 and out_ready = 0: out_data, out_sel and out_valid hold stable, and a_ready = b_ready = 0.
REQ-025 The last-grant pointer updates only on an input transfer, to the channel transferred; it is unchanged by a single-channel-valid cycle that does not transfer.
REQ-026 cnt_a / cnt_b increment by 1 on each channel-0 / channel-1 transfer; 16-bit wrap-around from 0xFFFF to 0x0000 with no saturation.
REQ-027 Input valid dropping without transfer is legal; no state changes.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, cnt_a = 0, cnt_b = 0, and the last-grant pointer = 1 (so channel 0 wins the first contention).
REQ-029 Reset asserted mid-transfer discards the slot word immediately, without waiting for a clock edge.
REQ-030 a_ready and b_ready are 0 while rst_n = 0.
REQ-031 After reset release, the first rising edge is able to accept a transfer.

Verification
REQ-032 Reset, then a_valid = b_valid = 1 with a_data = 0x11 and b_data = 0x22, out_ready = 1 held -> output sequence is 0x11/sel0, 0x22/sel1, 0x11/sel0, ... with one word per cycle; cnt_a and cnt_b differ by at most 1.
REQ-033 Only b_valid = 1 with b_data = 0x5A, out_ready = 1 -> out_valid is seen 1 cycle later with 0x5A and out_sel = 1; a_ready stays 0 throughout.
REQ-034 Output slot full (0x33), out_ready = 0 for 5 cycles, with both inputs valid -> out_data stays 0x33, a_ready = b_ready = 0, and both counters stay unchanged; when out_ready = 1, the next word is accepted in the same cycle.
REQ-035 Preload cnt_a to 0xFFFF via 65535 channel-0 transfers, then one more channel-0 transfer -> cnt_a = 0x0000 and cnt_b is unchanged.
REQ-036 rst_n pulsed low between edges while out_valid = 1 -> out_valid = 0 and both counters = 0 immediately; after release, contention grants channel 0 first.
